// File: rtl/integrator_threshold_trigger_if.sv
// Sample/threshold inputs and event-report outputs of the integrator threshold trigger.
interface integrator_threshold_trigger_if #(
  parameter int unsigned TOT_W = 8
);
  logic                    enable;
  logic signed [15:0]      x;
  logic signed [15:0]      threshold;
  logic                    trigger;
  logic                    ev_valid;
  logic signed [15:0]      peak;
  logic        [TOT_W-1:0] tot;
  logic                    busy;

  // Sample source / readout side.
  modport master (
    output enable, x, threshold,
    input  trigger, ev_valid, peak, tot, busy
  );

  // Discriminator side.
  modport slave (
    input  enable, x, threshold,
    output trigger, ev_valid, peak, tot, busy
  );
endinterface

// File: rtl/integrator_threshold_trigger.sv
// Self-trigger discriminator on the moving-integrator output: glitch rejection (MIN_TOT),
// hysteresis on event end, hold-off after each event, peak and time-over-threshold report.
module integrator_threshold_trigger #(
  parameter int unsigned HYST    = 8,
  parameter int unsigned MIN_TOT = 2,
  parameter int unsigned HOLDOFF = 64,
  parameter int unsigned TOT_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  integrator_threshold_trigger_if.slave  bus
);

  localparam int unsigned CntW   = $clog2(MIN_TOT + 1);
  localparam int unsigned HoW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned HoLast = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam logic [TOT_W-1:0]   TotMax = '1;
  localparam logic signed [16:0] HystS  = 17'(HYST);

  typedef enum logic [1:0] {StIdle, StConfirm, StActive, StHoldoff} state_e;

  // Input stage (x_r, en_r, rst_r)
  logic signed [15:0] x_q;
  logic               en_q;
  logic               rst_q;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [HoW-1:0]     ho_q, ho_d;
  logic signed [15:0] thr_q, thr_d;
  logic signed [15:0] peak_acc_q, peak_acc_d;
  logic [TOT_W-1:0]   tot_acc_q, tot_acc_d;
  logic               trig_q, trig_d;
  logic               ev_q, ev_d;
  logic signed [15:0] peak_q, peak_d;
  logic [TOT_W-1:0]   tot_q, tot_d;
  logic               busy_q, busy_d;

  logic signed [15:0] thr_cmp;
  logic signed [16:0] x_ext, thr_ext;
  logic               over, under;
  logic [TOT_W-1:0]   tot_inc;
  logic signed [15:0] peak_max;

  // Register the raw inputs once before any decision is made.
  always_ff @(posedge clk) begin
    x_q   <= bus.x;
    en_q  <= bus.enable;
    rst_q <= reset;
  end

  // Comparators and accumulator helpers; 17-bit compares keep thr - HYST from wrapping.
  always_comb begin
    thr_cmp  = (state_q == StIdle) ? bus.threshold : thr_q;
    x_ext    = {x_q[15], x_q};
    thr_ext  = {thr_cmp[15], thr_cmp};
    over     = x_ext > thr_ext;
    under    = x_ext < (thr_ext - HystS);
    tot_inc  = (tot_acc_q == TotMax) ? TotMax : tot_acc_q + TOT_W'(1);
    peak_max = (x_q > peak_acc_q) ? x_q : peak_acc_q;
  end

  // Next-state and registered-output logic; everything freezes on cycles without en_r.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ho_d       = ho_q;
    thr_d      = thr_q;
    peak_acc_d = peak_acc_q;
    tot_acc_d  = tot_acc_q;
    trig_d     = 1'b0;
    ev_d       = 1'b0;
    peak_d     = peak_q;
    tot_d      = tot_q;

    if (rst_q) begin
      state_d    = StIdle;
      cnt_d      = '0;
      ho_d       = '0;
      thr_d      = '0;
      peak_acc_d = '0;
      tot_acc_d  = '0;
      peak_d     = '0;
      tot_d      = '0;
    end else if (en_q) begin
      unique case (state_q)
        StIdle: begin
          if (over) begin
            thr_d      = bus.threshold;
            cnt_d      = CntW'(1);
            peak_acc_d = x_q;
            tot_acc_d  = TOT_W'(1);
            if (MIN_TOT == 1) begin
              trig_d  = 1'b1;
              state_d = StActive;
            end else begin
              state_d = StConfirm;
            end
          end
        end
        StConfirm: begin
          if (over) begin
            cnt_d      = cnt_q + CntW'(1);
            tot_acc_d  = tot_inc;
            peak_acc_d = peak_max;
            if (cnt_q + CntW'(1) == CntW'(MIN_TOT)) begin
              trig_d  = 1'b1;
              state_d = StActive;
            end
          end else begin
            // Too short: reject as a glitch without reporting anything.
            state_d = StIdle;
          end
        end
        StActive: begin
          if (under) begin
            ev_d    = 1'b1;
            peak_d  = peak_acc_q;
            tot_d   = tot_acc_q;
            ho_d    = '0;
            state_d = (HOLDOFF == 0) ? StIdle : StHoldoff;
          end else begin
            tot_acc_d  = tot_inc;
            peak_acc_d = peak_max;
          end
        end
        StHoldoff: begin
          if (ho_q == HoW'(HoLast)) begin
            ho_d    = '0;
            state_d = StIdle;
          end else begin
            ho_d = ho_q + HoW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = !rst_q && (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    cnt_q      <= cnt_d;
    ho_q       <= ho_d;
    thr_q      <= thr_d;
    peak_acc_q <= peak_acc_d;
    tot_acc_q  <= tot_acc_d;
    trig_q     <= trig_d;
    ev_q       <= ev_d;
    peak_q     <= peak_d;
    tot_q      <= tot_d;
    busy_q     <= busy_d;
  end

  assign bus.trigger  = trig_q;
  assign bus.ev_valid = ev_q;
  assign bus.peak     = peak_q;
  assign bus.tot      = tot_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_integrator_threshold_trigger.sv
// Directed and randomized bench for integrator_threshold_trigger against an event-level model.
module tb_integrator_threshold_trigger;
  localparam int HYST    = 8;
  localparam int MIN_TOT = 2;
  localparam int HOLDOFF = 64;
  localparam int TOT_W   = 8;
  localparam int TOT_MAX = (1 << TOT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  integrator_threshold_trigger_if #(.TOT_W(TOT_W)) bus ();

  integrator_threshold_trigger #(
    .HYST   (HYST),
    .MIN_TOT(MIN_TOT),
    .HOLDOFF(HOLDOFF),
    .TOT_W  (TOT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Event-level reference: over-threshold run length, in-event flag, hold-off samples left.
  int m_thr_l, m_run, m_in_event, m_ho_left, m_peak_acc, m_tot_acc;
  int e_trig, e_ev, e_busy, e_peak, e_tot;
  bit pend = 0;
  int thr_v = 1000;
  int n_trig_obs = 0;
  int n_ev_obs   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model(input int x, input bit en, input bit rst);
    if (rst) begin
      m_run = 0; m_in_event = 0; m_ho_left = 0; m_peak_acc = 0; m_tot_acc = 0;
      e_trig = 0; e_ev = 0; e_busy = 0; e_peak = 0; e_tot = 0;
      return;
    end
    e_trig = 0;
    e_ev   = 0;
    if (!en) return;
    if (m_ho_left > 0) begin
      m_ho_left--;
    end else if (m_in_event != 0) begin
      if (x < m_thr_l - HYST) begin
        e_ev = 1; e_peak = m_peak_acc; e_tot = m_tot_acc;
        m_in_event = 0; m_ho_left = HOLDOFF;
      end else begin
        m_tot_acc  = (m_tot_acc + 1 > TOT_MAX) ? TOT_MAX : m_tot_acc + 1;
        m_peak_acc = (x > m_peak_acc) ? x : m_peak_acc;
      end
    end else if (m_run > 0) begin
      if (x > m_thr_l) begin
        m_run++;
        m_tot_acc  = (m_tot_acc + 1 > TOT_MAX) ? TOT_MAX : m_tot_acc + 1;
        m_peak_acc = (x > m_peak_acc) ? x : m_peak_acc;
        if (m_run >= MIN_TOT) begin
          e_trig = 1; m_in_event = 1; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (x > thr_v) begin
      m_thr_l = thr_v; m_run = 1; m_tot_acc = 1; m_peak_acc = x;
      if (MIN_TOT == 1) begin
        e_trig = 1; m_in_event = 1; m_run = 0;
      end
    end
    e_busy = (m_run > 0 || m_in_event != 0 || m_ho_left > 0) ? 1 : 0;
  endtask

  // Present one sample; outputs for the previous sample are checked after this edge.
  task automatic step(input int x, input bit en = 1'b1, input bit rst = 1'b0);
    bus.x         = 16'(x);
    bus.enable    = en;
    bus.threshold = 16'(thr_v);
    reset         = rst;
    @(posedge clk);
    #1;
    if (pend) begin
      check("trigger",  32'(bus.trigger),  32'(e_trig));
      check("ev_valid", 32'(bus.ev_valid), 32'(e_ev));
      check("busy",     32'(bus.busy),     32'(e_busy));
      check("peak",     32'(bus.peak),     32'(e_peak));
      check("tot",      32'(bus.tot),      32'(e_tot));
      n_trig_obs += int'(bus.trigger);
      n_ev_obs   += int'(bus.ev_valid);
    end
    model(x, en, rst);
    pend = 1;
  endtask

  task automatic idle(input int n, input int x = 0);
    for (int i = 0; i < n; i++) step(x);
  endtask

  initial begin
    int amp, len, gap;
    bus.x = '0; bus.enable = 1'b0; bus.threshold = 16'(thr_v); reset = 1'b1;

    // Reset and quiescent input
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1);
    n_trig_obs = 0; n_ev_obs = 0;
    idle(100);
    check("t1_trig_cnt", 32'(n_trig_obs), 32'd0);
    check("t1_ev_cnt",   32'(n_ev_obs),   32'd0);

    // Single-sample glitch
    step(2000);
    idle(5);
    check("t2_trig_cnt", 32'(n_trig_obs), 32'd0);
    check("t2_ev_cnt",   32'(n_ev_obs),   32'd0);

    // Clean pulse
    n_trig_obs = 0; n_ev_obs = 0;
    step(1500); step(1600); step(1800); step(1700); step(1500);
    idle(80);
    check("t3_trig_cnt", 32'(n_trig_obs), 32'd1);
    check("t3_ev_cnt",   32'(n_ev_obs),   32'd1);
    check("t3_peak",     32'(bus.peak),   32'd1800);
    check("t3_tot",      32'(bus.tot),    32'd5);

    // Hysteresis band keeps the event alive
    step(1500); step(1500); step(995); step(995); step(1500); step(900);
    idle(80);
    check("t4_peak", 32'(bus.peak), 32'd1500);
    check("t4_tot",  32'(bus.tot),  32'd5);

    // Hold-off blocks an early re-trigger but not a late one
    n_trig_obs = 0;
    step(1500); step(1500); step(0);
    idle(9);
    step(1500); step(1500); step(1500); step(0);
    idle(2);
    check("t5_blocked", 32'(n_trig_obs), 32'd1);
    idle(60);
    step(1500); step(1500); step(0);
    idle(2);
    check("t5_retrig", 32'(n_trig_obs), 32'd2);
    idle(70);

    // Negative threshold with a ramp from full-scale negative
    idle(3, -32768);
    thr_v = -100;
    idle(3, -32768);
    n_trig_obs = 0;
    for (int i = 0; i < 128; i++) step(-32768 + 256 * i);
    idle(2, -32768);
    check("t6_no_false", 32'(n_trig_obs), 32'd0);
    step(0); step(0); step(0); step(-32768);
    idle(2, -32768);
    check("t6_ramp_trig", 32'(n_trig_obs), 32'd1);
    idle(70, -32768);

    // Lowest possible threshold: the event can never end, so reset it away
    thr_v = -32768;
    step(-32767); step(-32767); step(-32767); step(-32768); step(-32768);
    n_ev_obs = 0;
    step(-32768, 1'b1, 1'b1);
    idle(4, -32768);
    check("t6_min_thr_no_ev", 32'(n_ev_obs), 32'd0);
    thr_v = 1000;
    idle(5);

    // Disabled cycles mid-event are not counted
    step(1500); step(1500); step(1500);
    for (int i = 0; i < 10; i++) step(1500, 1'b0);
    step(1500); step(1500); step(0);
    idle(70);
    check("t6_en_tot", 32'(bus.tot), 32'd5);

    // Reset mid-event discards it
    n_ev_obs = 0;
    step(1500); step(1600); step(1700); step(1500);
    step(0, 1'b1, 1'b1);
    idle(5);
    check("t6_rst_no_ev", 32'(n_ev_obs), 32'd0);
    check("t6_rst_busy",  32'(bus.busy), 32'd0);

    // Long pulse saturates the time-over-threshold count
    for (int i = 0; i < 300; i++) step(1200 + (i % 50));
    idle(80);
    check("tot_sat", 32'(bus.tot), 32'(TOT_MAX));

    // Randomized pulses, thresholds, enable gaps and dips into the hysteresis band
    for (int p = 0; p < 40; p++) begin
      thr_v = int'($urandom_range(200, 3000));
      idle(2);
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        amp = thr_v - 20 + int'($urandom_range(0, 800));
        step(amp, ($urandom_range(0, 9) != 0));
      end
      gap = int'($urandom_range(5, 100));
      for (int i = 0; i < gap; i++) step(0, ($urandom_range(0, 7) != 0));
      idle(80);
    end

    step(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
